// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer: MSB-first, WIDTH-bit transfers, SCLK = clk/(2*CLK_DIV).
// done/ready rise (2*WIDTH+2)*CLK_DIV cycles after the accepting edge; start is ignored while busy.
module spi_master_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  output logic             mosi_oe,
  input  logic             miso
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      rx_data <= '0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      mosi_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr      <= tx_data;
            cs_n    <= 1'b0;
            mosi_oe <= 1'b1;
            mosi    <= tx_data[WIDTH-1];
            ready   <= 1'b0;
            div_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (tick) begin
            div_cnt <= '0;
            if (sclk) begin
              // MISO is taken at the end of the high phase, as SCLK falls
              sclk <= 1'b0;
              sr   <= {sr[WIDTH-2:0], miso};
              mosi <= sr[WIDTH-2];
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                state   <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              sclk <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          // Hold spans a full SCLK period (two divider ticks) with SCLK low
          if (tick) begin
            div_cnt <= '0;
            if (bit_cnt != '0) begin
              bit_cnt <= '0;
              cs_n    <= 1'b1;
              mosi_oe <= 1'b0;
              mosi    <= 1'b0;
              rx_data <= sr;
              done    <= 1'b1;
              ready   <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_cnt <= BW'(1);
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1) share clk/rst; sel picks the active one.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso = 1'b0;

  logic       ready0, done0, sclk0, cs_n0, mosi0, mosi_oe0, start0;
  logic       ready1, done1, sclk1, cs_n1, mosi1, mosi_oe1, start1;
  logic [7:0] rx0, rx1;

  logic       m_ready, m_done, m_sclk, m_cs_n, m_mosi, m_mosi_oe;
  logic [7:0] m_rx;

  assign start0    = start & ~sel;
  assign start1    = start & sel;
  assign m_ready   = sel ? ready1   : ready0;
  assign m_done    = sel ? done1    : done0;
  assign m_sclk    = sel ? sclk1    : sclk0;
  assign m_cs_n    = sel ? cs_n1    : cs_n0;
  assign m_mosi    = sel ? mosi1    : mosi0;
  assign m_mosi_oe = sel ? mosi_oe1 : mosi_oe0;
  assign m_rx      = sel ? rx1      : rx0;

  spi_master_ctrl #(.WIDTH(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start0), .tx_data(tx_data),
    .ready(ready0), .done(done0), .rx_data(rx0), .sclk(sclk0),
    .cs_n(cs_n0), .mosi(mosi0), .mosi_oe(mosi_oe0), .miso(miso)
  );

  spi_master_ctrl #(.WIDTH(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .tx_data(tx_data),
    .ready(ready1), .done(done1), .rx_data(rx1), .sclk(sclk1),
    .cs_n(cs_n1), .mosi(mosi1), .mosi_oe(mosi_oe1), .miso(miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: presents its word MSB first, advancing only after SCLK falls; or loops MOSI back
  logic [7:0] slv_word = 8'h00;
  bit         loop_mode = 1'b0;
  int         fcnt = 0;
  logic       s_prev = 1'b0;
  always @(negedge clk) begin
    if (m_cs_n) fcnt = 0;
    else if (s_prev && !m_sclk) fcnt++;
    s_prev = m_sclk;
    if (loop_mode) miso = m_mosi;
    else miso = (fcnt < 8) ? slv_word[7 - fcnt] : 1'b0;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_rx(input logic [7:0] tx, input logic [7:0] slv, input bit lp);
    return lp ? tx : slv;
  endfunction

  function automatic int model_lat(input int div);
    return (2 * 8 + 2) * div;
  endfunction

  task automatic begin_xfer(input logic [7:0] tx, input bit hold, output int t0);
    for (int k = 0; k < 100 && !m_ready; k++) @(negedge clk);
    if (!m_ready) chk("ready_wait_timeout", 32'd0, 32'd1);
    start   = 1'b1;
    tx_data = tx;
    @(posedge clk);
    @(negedge clk);
    t0      = cyc;
    start   = hold;
    tx_data = 8'($urandom);
  endtask

  // Observes one transfer from the negedge after the accepting edge up to the done cycle
  task automatic watch(input logic [7:0] tx, input logic [7:0] exp_rx, input int div,
                       input bit busy, input int t0);
    int   rises = 0, lowcnt = 0, bad_oe = 0, bad_edge = 0, off;
    logic [7:0] bits = 8'h00;
    logic ps = 1'b0, pc = 1'b1;
    bit   seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      if (k > 0) @(negedge clk);
      if (m_sclk && !ps) begin
        rises++;
        bits = {bits[6:0], m_mosi};
      end
      if (m_cs_n != pc && m_sclk) bad_edge++;
      if (m_mosi_oe !== ~m_cs_n) bad_oe++;
      if (!m_cs_n) lowcnt++;
      off = cyc - t0;
      if (busy) start = (off == 5 || off == 17 || off == 30);
      if (m_done) seen = 1'b1;
      ps = m_sclk;
      pc = m_cs_n;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_latency", 32'(cyc - t0), 32'(model_lat(div)));
    chk("sclk_rises", 32'(rises), 32'd8);
    chk("mosi_bits", 32'(bits), 32'(tx));
    chk("rx_data", 32'(m_rx), 32'(exp_rx));
    chk("cs_low_cycles", 32'(lowcnt), 32'(model_lat(div)));
    chk("mosi_oe_track", 32'(bad_oe), 32'd0);
    chk("sclk_low_at_cs_edge", 32'(bad_edge), 32'd0);
    chk("ready_at_done", 32'(m_ready), 32'd1);
  endtask

  task automatic do_xfer(input bit s, input logic [7:0] tx, input logic [7:0] slv,
                         input bit lp, input logic [7:0] exp_rx, input bit busy);
    int t0;
    sel       = s;
    slv_word  = slv;
    loop_mode = lp;
    begin_xfer(tx, 1'b0, t0);
    watch(tx, exp_rx, s ? 1 : 2, busy, t0);
    start = 1'b0;
    @(negedge clk);
    chk("done_pulse_width", 32'(m_done), 32'd0);
  endtask

  typedef struct packed {
    logic       s;
    logic [7:0] tx;
    logic [7:0] slv;
    logic       lp;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vt[4];
  vec_t v;
  int   t0, t0b, r, quiet;
  logic ps;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 8'hA5, 8'h00, 1'b1, 8'hA5};
    vt[1] = '{1'b0, 8'hFF, 8'h3C, 1'b0, 8'h3C};
    vt[2] = '{1'b1, 8'h81, 8'h00, 1'b1, 8'h81};
    vt[3] = '{1'b1, 8'h00, 8'hC3, 1'b0, 8'hC3};

    // Reset state is visible without any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(ready0), 32'd1);
    chk("rst_cs_n", 32'(cs_n0), 32'd1);
    chk("rst_sclk", 32'(sclk0), 32'd0);
    chk("rst_mosi_oe", 32'(mosi_oe0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_rx", 32'(rx0), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      v = vt[i];
      do_xfer(v.s, v.tx, v.slv, v.lp, v.exp_rx, 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      v.s   = 1'($urandom_range(0, 1));
      v.tx  = 8'($urandom);
      v.slv = 8'($urandom);
      v.lp  = 1'($urandom_range(0, 1));
      do_xfer(v.s, v.tx, v.slv, v.lp, model_rx(v.tx, v.slv, v.lp), 1'b0);
    end

    // Start pulses while busy: one done, no second transfer afterwards
    do_xfer(1'b0, 8'h96, 8'h69, 1'b0, 8'h69, 1'b1);
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (!m_cs_n || m_done) quiet++;
    end
    chk("busy_start_ignored", 32'(quiet), 32'd0);

    // start held across done: next transfer follows after a single cs_n-high cycle
    sel = 1'b0;
    loop_mode = 1'b1;
    begin_xfer(8'h3C, 1'b1, t0);
    watch(8'h3C, 8'h3C, 2, 1'b0, t0);
    chk("b2b_cs_high_at_done", 32'(m_cs_n), 32'd1);
    tx_data = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    t0b = cyc;
    chk("b2b_done_width", 32'(m_done), 32'd0);
    chk("b2b_cs_gap_one", 32'(m_cs_n), 32'd0);
    chk("b2b_ready_low", 32'(m_ready), 32'd0);
    start = 1'b0;
    tx_data = 8'($urandom);
    watch(8'hC3, 8'hC3, 2, 1'b0, t0b);
    @(negedge clk);
    chk("b2b_second_done_width", 32'(m_done), 32'd0);

    // Reset in the middle of bit 4
    sel = 1'b0;
    loop_mode = 1'b1;
    begin_xfer(8'hC7, 1'b0, t0);
    r = 0;
    ps = 1'b0;
    for (int k = 0; k < 200 && r < 4; k++) begin
      @(negedge clk);
      if (m_sclk && !ps) r++;
      ps = m_sclk;
    end
    chk("mid_rises_reached", 32'(r), 32'd4);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs_n", 32'(m_cs_n), 32'd1);
    chk("mid_rst_sclk", 32'(m_sclk), 32'd0);
    chk("mid_rst_mosi_oe", 32'(m_mosi_oe), 32'd0);
    chk("mid_rst_mosi", 32'(m_mosi), 32'd0);
    chk("mid_rst_ready", 32'(m_ready), 32'd1);
    chk("mid_rst_rx", 32'(m_rx), 32'd0);
    quiet = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_done) quiet++;
    end
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (m_done || !m_cs_n) quiet++;
    end
    chk("mid_rst_no_done", 32'(quiet), 32'd0);
    do_xfer(1'b0, 8'h5A, 8'h00, 1'b1, 8'h5A, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
